// File: rtl/reg_heap_pkg.sv
// Shared CPU constants for the register heap: data width, address width, entry count.
// Zero-latency reads, no backpressure.
package reg_heap_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;
  localparam int CPU_NREG   = 2 ** CPU_ADDR_W;

endpackage : reg_heap_pkg

// File: rtl/reg_heap_word.sv
// One storage word: DATA_W-bit register with sync active-low clear and write enable.
// Updates on the rising edge; no backpressure.
module reg_word #(
  parameter int DATA_W = reg_heap_pkg::CPU_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // Clear has priority over a concurrent write.
  always_comb begin
    data_d = data_q;
    if (!clr) begin
      data_d = '0;
    end else if (we) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule : reg_word

// File: rtl/reg_heap.sv
// 32-entry register heap with two combinational read ports and one write port.
// Reads have zero latency; writes land on the rising edge. Entry 0 is hard-wired to zero.
module reg_heap
  import reg_heap_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] o_A,
  output logic [DATA_W-1:0] o_B,
  input  logic [ADDR_W-1:0] rd,
  input  logic              s_write,
  input  logic [DATA_W-1:0] W
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:1]   we_onehot;

  // Entry 0 has no storage, so writes to rd=0 simply have nowhere to go.
  assign regs[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_word
    assign we_onehot[i] = s_write && (rd == ADDR_W'(i));

    reg_word #(
      .DATA_W (DATA_W)
    ) u_word (
      .clk (clk),
      .clr (clr),
      .we  (we_onehot[i]),
      .d   (W),
      .q   (regs[i])
    );
  end

  assign o_A = regs[rs];
  assign o_B = regs[rt];

endmodule : reg_heap

// File: tb/tb_reg_heap.sv
// Directed bench for reg_heap: reset sweep, write/read, r0, hold, reset priority, port independence.
module tb_reg_heap;

  logic        clk;
  logic        clr;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] o_A;
  logic [31:0] o_B;
  logic [4:0]  rd;
  logic        s_write;
  logic [31:0] W;

  int total;
  int bad;

  reg_heap dut (
    .clk     (clk),
    .clr     (clr),
    .rs      (rs),
    .rt      (rt),
    .o_A     (o_A),
    .o_B     (o_B),
    .rd      (rd),
    .s_write (s_write),
    .W       (W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    s_write = 1'b1;
    rd = 5'd9;
    W = 32'hCAFE_F00D;
    repeat (3) tick();
    s_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i);
      rt = 5'(31 - i);
      #1;
      total++;
      if (o_A !== 32'h0) begin
        bad++;
        $display("FAIL reset_sweep_A addr=%0d got=%h want=%h", i, o_A, 32'h0);
      end
      total++;
      if (o_B !== 32'h0) begin
        bad++;
        $display("FAIL reset_sweep_B addr=%0d got=%h want=%h", 31 - i, o_B, 32'h0);
      end
    end
    clr = 1'b1;
  endtask

  task automatic test_write_read();
    s_write = 1'b1;
    rd = 5'd4;
    W = 32'h0000_ABCD;
    rs = 5'd4;
    #1;
    total++;
    if (o_A !== 32'h0) begin
      bad++;
      $display("FAIL pre_edge_old got=%h want=%h", o_A, 32'h0);
    end
    tick();
    s_write = 1'b0;
    total++;
    if (o_A !== 32'h0000_ABCD) begin
      bad++;
      $display("FAIL write_r4 got=%h want=%h", o_A, 32'h0000_ABCD);
    end
    rt = 5'd5;
    #1;
    total++;
    if (o_B !== 32'h0) begin
      bad++;
      $display("FAIL r5_untouched got=%h want=%h", o_B, 32'h0);
    end
  endtask

  task automatic test_write_zero();
    s_write = 1'b1;
    rd = 5'd0;
    W = 32'hFFFF_FFFF;
    tick();
    s_write = 1'b0;
    rs = 5'd0;
    rt = 5'd4;
    #1;
    total++;
    if (o_A !== 32'h0) begin
      bad++;
      $display("FAIL r0_write_dropped got=%h want=%h", o_A, 32'h0);
    end
    total++;
    if (o_B !== 32'h0000_ABCD) begin
      bad++;
      $display("FAIL r0_write_side_effect got=%h want=%h", o_B, 32'h0000_ABCD);
    end
  endtask

  task automatic test_no_write();
    s_write = 1'b0;
    rd = 5'd4;
    W = 32'h0000_1234;
    repeat (4) tick();
    rs = 5'd4;
    #1;
    total++;
    if (o_A !== 32'h0000_ABCD) begin
      bad++;
      $display("FAIL hold_no_we got=%h want=%h", o_A, 32'h0000_ABCD);
    end
  endtask

  task automatic test_reset_override();
    s_write = 1'b1;
    rd = 5'd7;
    W = 32'h11;
    tick();
    rs = 5'd7;
    #1;
    total++;
    if (o_A !== 32'h11) begin
      bad++;
      $display("FAIL r7_write got=%h want=%h", o_A, 32'h11);
    end
    clr = 1'b0;
    W = 32'h22;
    tick();
    clr = 1'b1;
    s_write = 1'b0;
    total++;
    if (o_A !== 32'h0) begin
      bad++;
      $display("FAIL reset_beats_write got=%h want=%h", o_A, 32'h0);
    end
    rt = 5'd4;
    #1;
    total++;
    if (o_B !== 32'h0) begin
      bad++;
      $display("FAIL reset_clears_r4 got=%h want=%h", o_B, 32'h0);
    end
  endtask

  task automatic test_two_ports();
    s_write = 1'b1;
    rd = 5'd31;
    W = 32'hDEAD_BEEF;
    tick();
    rd = 5'd1;
    W = 32'h1;
    tick();
    s_write = 1'b0;
    rs = 5'd31;
    rt = 5'd1;
    #1;
    total++;
    if (o_A !== 32'hDEAD_BEEF || o_B !== 32'h1) begin
      bad++;
      $display("FAIL ports_31_1 got=%h/%h want=%h/%h", o_A, o_B, 32'hDEAD_BEEF, 32'h1);
    end
    rs = 5'd1;
    rt = 5'd31;
    #1;
    total++;
    if (o_A !== 32'h1 || o_B !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL ports_swapped got=%h/%h want=%h/%h", o_A, o_B, 32'h1, 32'hDEAD_BEEF);
    end
    rs = 5'd31;
    #1;
    total++;
    if (o_A !== 32'hDEAD_BEEF || o_B !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL ports_same_addr got=%h/%h want=%h/%h", o_A, o_B, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_isolation();
    logic [31:0] exp_val;
    s_write = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd = 5'(i);
      W = {8'hA5, 8'(i), 8'h5A, 8'(~i)};
      tick();
    end
    rd = 5'd16;
    W = 32'h0BAD_0BAD;
    tick();
    s_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 0) exp_val = 32'h0;
      else if (i == 16) exp_val = 32'h0BAD_0BAD;
      else exp_val = {8'hA5, 8'(i), 8'h5A, 8'(~i)};
      rs = 5'(i);
      rt = 5'(i);
      #1;
      total++;
      if (o_A !== exp_val || o_B !== exp_val) begin
        bad++;
        $display("FAIL isolation addr=%0d got=%h/%h want=%h", i, o_A, o_B, exp_val);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    clr = 1'b0;
    s_write = 1'b0;
    rs = '0;
    rt = '0;
    rd = '0;
    W = '0;
    #2;
    test_reset();
    test_write_read();
    test_write_zero();
    test_no_write();
    test_reset_override();
    test_two_ports();
    test_isolation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_heap

// File: doc/reg_heap.md
REG_HEAP -- requirements
Module: reg_heap

Interface
REQ-001 Parameter DATA_W, default 32, width of each register and of every data port.
REQ-002 Parameter ADDR_W, default 5, address width; register count is 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 clr  input  1  reset, synchronous, active-low (clr=0 resets on the rising clk edge).
REQ-005 rs  input  ADDR_W  read address, port A.
REQ-006 rt  input  ADDR_W  read address, port B.
REQ-007 o_A  output  DATA_W  read data, port A.
REQ-008 o_B  output  DATA_W  read data, port B.
REQ-009 rd  input  ADDR_W  write address.
REQ-010 s_write  input  1  write enable, active-high.
REQ-011 W  input  DATA_W  write data.

Function
REQ-012 The block SHALL hold 32 registers of DATA_W bits, indexed 0..31.
REQ-013 Reads SHALL be combinational: o_A = reg[rs], o_B = reg[rt], with no clock latency, and SHALL track address changes within the same cycle.
REQ-014 Register 0 SHALL always read as 0 on both ports, regardless of any write to address 0.
REQ-015 On a rising clk edge with clr=1, s_write=1 and rd!=0, reg[rd] SHALL take W; the new value SHALL be visible on o_A/o_B immediately after that edge.
REQ-016 With s_write=0, no register SHALL change.
REQ-017 A write with rd=0 SHALL be discarded.
REQ-018 A simultaneous read and write of the same address SHALL return the old value before the edge and the new value after it; no write-to-read bypass is required.
REQ-019 rs and rt SHALL be independent; rs=rt SHALL give identical o_A and o_B.
REQ-020 Only reg[rd] SHALL change on a write; all other registers SHALL keep their values.

Reset
REQ-021 On a rising clk edge with clr=0, all 32 registers SHALL become 0, overriding any concurrent write.
REQ-022 While clr=0 is held across several edges, all registers SHALL stay 0 and o_A/o_B SHALL read 0 for every address.
REQ-023 Before the first reset edge, register contents are undefined; benches SHALL apply reset before checking outputs.

Structure
REQ-024 DATA_W, ADDR_W and the register count SHALL be defined as constants in the shared CPU package.
REQ-025 The storage SHALL be built from a sub-module reg_word: a DATA_W-bit register with sync active-low clear and write enable, instantiated for addresses 1..31.
REQ-026 Address 0 SHALL be a constant-zero entry, not a reg_word instance.
REQ-027 Write-enable decode (rd plus s_write to one-hot) and the two read multiplexers SHALL be in the top level.

Verification
REQ-028 Hold clr=0 for 3 edges, then sweep rs/rt over 0..31 -> o_A=o_B=0 for every address.
REQ-029 clr=1, s_write=1, rd=4, W=32'h0000ABCD, one edge; then s_write=0, rs=4 -> o_A=32'h0000ABCD after the edge; rt=5 -> o_B=0.
REQ-030 s_write=1, rd=0, W=32'hFFFFFFFF, one edge; rs=0 -> o_A=0.
REQ-031 reg4=32'hABCD; s_write=0, rd=4, W=32'h1234, several edges -> rs=4 still reads 32'hABCD.
REQ-032 Write 32'h11 to reg7, then on the next edge drive clr=0, s_write=1, rd=7, W=32'h22 -> rs=7 reads 0 after that edge.
REQ-033 Write reg31=32'hDEADBEEF and reg1=32'h1; rs=31, rt=1 -> o_A=32'hDEADBEEF, o_B=32'h1; swap rs and rt -> outputs swap in the same cycle.
